// File: rtl/noc_types_pkg.sv
// Shared NoC router types: port direction encoding and flit layout.
package noc_types;

  // Router port directions; also used as the output index of the crossbar.
  typedef enum logic [1:0] {
    NORTH = 2'd0,
    EAST  = 2'd1,
    SOUTH = 2'd2,
    WEST  = 2'd3
  } e_dir;

  localparam int DIR_W  = 2;
  localparam int FLIT_W = 7;

  // Crossbar word as carried through a node: enable bit on top of the flit.
  typedef struct packed {
    logic              en;
    logic [FLIT_W-1:0] data;
  } flit_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with sticky (wormhole) grants. Grant is combinational
// from req; owner/ptr are updated on the clock edge.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  int            idx;

  // Pick the winner: held owner first, else first requester after ptr.
  // Reset forces the grant off so nothing leaks while rst is high.
  always_comb begin
    win       = '0;
    cand      = '0;
    idx       = 0;
    gnt_valid = 1'b0;
    if (!rst) begin
      if (valid_q && req[owner_q]) begin
        win       = owner_q;
        gnt_valid = 1'b1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          idx = int'(ptr_q) + k;
          if (idx >= N) idx = idx - N;
          cand = IW'(idx);
          if (!gnt_valid && req[cand]) begin
            win       = cand;
            gnt_valid = 1'b1;
          end
        end
      end
    end
  end

  // One-hot view of the winner.
  always_comb begin
    gnt = '0;
    if (gnt_valid) gnt[win] = 1'b1;
  end

  // Next state: a grant becomes (or stays) the held owner; none releases.
  always_comb begin
    owner_d = owner_q;
    ptr_d   = ptr_q;
    valid_d = gnt_valid;
    if (gnt_valid) begin
      owner_d = win;
      ptr_d   = win;
    end
  end

  // State register; ptr resets to N-1 so index 0 has first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= IW'(N - 1);
      owner_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/crossbar_rr.sv
// PORTS x PORTS zero-latency crossbar. One sticky round-robin arbiter per
// output; data is muxed forward, backpressure is muxed back to the winner.
module crossbar_rr
  import noc_types::*;
#(
  parameter int PORTS = 4,
  parameter int WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORTS-1:0][WIDTH-1:0]       data_i,
  input  logic [PORTS-1:0]                  bp_i,
  input  logic [PORTS-1:0][DIR_W-1:0]       dest,
  input  logic [PORTS-1:0]                  dest_en,
  output logic [PORTS-1:0][WIDTH-1:0]       data_o,
  output logic [PORTS-1:0]                  bp_o,
  output logic [PORTS-1:0]                  ack
);

  // Indexed [output][input].
  logic [PORTS-1:0][PORTS-1:0] req;
  logic [PORTS-1:0][PORTS-1:0] gnt;
  logic [PORTS-1:0]            gnt_vld;

  // Request matrix and one arbiter per output. dest is DIR_W wide, so
  // PORTS is bounded by 2**DIR_W.
  for (genvar o = 0; o < PORTS; o++) begin : g_out
    for (genvar i = 0; i < PORTS; i++) begin : g_in
      assign req[o][i] = dest_en[i] && (dest[i] == DIR_W'(o));
    end

    rr_arbiter #(.N(PORTS)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req[o]),
      .gnt       (gnt[o]),
      .gnt_valid (gnt_vld[o])
    );
  end

  // Data forward mux, ack and backpressure return. An input requests a
  // single output, so at most one gnt bit per input column is ever set.
  always_comb begin
    data_o = '0;
    ack    = '0;
    bp_o   = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (gnt_vld[o] && gnt[o][i]) begin
          data_o[o] = data_i[i];
          ack[i]    = 1'b1;
          bp_o[i]   = bp_i[o];
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_rr.sv
// Bench for crossbar_rr: vector table plus hand-built sticky/reset sequences,
// expected outputs queued at drive time and checked mid-cycle.
module tb_crossbar_rr;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][7:0]  data_i;
  logic [3:0]       bp_i;
  logic [3:0][1:0]  dest;
  logic [3:0]       dest_en;
  logic [3:0][7:0]  data_o;
  logic [3:0]       bp_o;
  logic [3:0]       ack;

  crossbar_rr #(.PORTS(4), .WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .bp_i    (bp_i),
    .dest    (dest),
    .dest_en (dest_en),
    .data_o  (data_o),
    .bp_o    (bp_o),
    .ack     (ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  en;
    logic [7:0]  dst;   // {dest3, dest2, dest1, dest0}
    logic [31:0] dat;   // {data3, data2, data1, data0}
    logic [3:0]  bp;
    logic [31:0] xdat;  // {out3, out2, out1, out0}
    logic [3:0]  xack;
    logic [3:0]  xbpo;
  } vec_t;

  localparam logic [31:0] DAT = 32'h44332211;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(string n, logic r, logic [3:0] en, logic [7:0] dst,
                              logic [31:0] dat, logic [3:0] bp,
                              logic [31:0] xdat, logic [3:0] xack, logic [3:0] xbpo);
    vec_t v;
    v.name = n; v.rst = r; v.en = en; v.dst = dst; v.dat = dat; v.bp = bp;
    v.xdat = xdat; v.xack = xack; v.xbpo = xbpo;
    tbl.push_back(v);
  endfunction

  task automatic check();
    vec_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard empty");
      return;
    end
    e = sb.pop_front();
    tests++;
    if (data_o !== e.xdat) begin
      fails++;
      $display("FAIL %s data_o: got %h want %h", e.name, data_o, e.xdat);
    end
    tests++;
    if (ack !== e.xack) begin
      fails++;
      $display("FAIL %s ack: got %b want %b", e.name, ack, e.xack);
    end
    tests++;
    if (bp_o !== e.xbpo) begin
      fails++;
      $display("FAIL %s bp_o: got %b want %b", e.name, bp_o, e.xbpo);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    rst     = v.rst;
    dest_en = v.en;
    dest    = v.dst;
    data_i  = v.dat;
    bp_i    = v.bp;
    sb.push_back(v);
    @(negedge clk);
    check();
  endtask

  task automatic step(string n, logic r, logic [3:0] en, logic [7:0] dst,
                      logic [31:0] dat, logic [3:0] bp,
                      logic [31:0] xdat, logic [3:0] xack, logic [3:0] xbpo);
    vec_t v;
    v.name = n; v.rst = r; v.en = en; v.dst = dst; v.dat = dat; v.bp = bp;
    v.xdat = xdat; v.xack = xack; v.xbpo = xbpo;
    apply(v);
  endtask

  initial begin
    rst = 1'b1; dest_en = '0; dest = '0; data_i = '0; bp_i = '0;

    // Reset forces everything off even with all inputs requesting.
    add("reset_hold",  1, 4'b1111, 8'h00, DAT, 4'hF, 32'h0, 4'b0000, 4'b0000);
    add("reset_hold2", 1, 4'b1111, 8'h00, DAT, 4'hF, 32'h0, 4'b0000, 4'b0000);
    // Single request: in1 -> out2, bp_i[2]=1.
    add("single",      0, 4'b0010, 8'h08, 32'h4433A511, 4'b0100, 32'h00A50000, 4'b0010, 4'b0010);
    // dest=1 with dest_en=0: nothing moves whatever bp_i is.
    add("disabled",    0, 4'b0000, 8'h04, DAT, 4'hF, 32'h0, 4'b0000, 4'b0000);
    // in0 and in3 contend for out1: 0, then 3, then 0.
    add("rr_first0",   0, 4'b1001, 8'h41, DAT, 4'b0010, 32'h00001100, 4'b0001, 4'b0001);
    add("rr_drop1",    0, 4'b0000, 8'h41, DAT, 4'b0010, 32'h0, 4'b0000, 4'b0000);
    add("rr_then3",    0, 4'b1001, 8'h41, DAT, 4'b0010, 32'h00004400, 4'b1000, 4'b1000);
    add("rr_drop2",    0, 4'b0000, 8'h41, DAT, 4'b0010, 32'h0, 4'b0000, 4'b0000);
    add("rr_back0",    0, 4'b1001, 8'h41, DAT, 4'b0010, 32'h00001100, 4'b0001, 4'b0001);
    add("rr_drop3",    0, 4'b0000, 8'h41, DAT, 4'b0010, 32'h0, 4'b0000, 4'b0000);
    // Parallel paths 0->1, 1->0, 2->3, 3->2 with bp_i toggling.
    add("par_bp0",     0, 4'b1111, 8'hB1, DAT, 4'b0000, 32'h33441122, 4'b1111, 4'b0000);
    add("par_bp5",     0, 4'b1111, 8'hB1, DAT, 4'b0101, 32'h33441122, 4'b1111, 4'b1010);
    add("par_bpA",     0, 4'b1111, 8'hB1, DAT, 4'b1010, 32'h33441122, 4'b1111, 4'b0101);
    add("par_drop",    0, 4'b0000, 8'hB1, DAT, 4'hF, 32'h0, 4'b0000, 4'b0000);

    foreach (tbl[k]) apply(tbl[k]);

    // Stickiness: out0 ptr is 1 now, so in2 wins, then holds against in1.
    step("sticky_own", 0, 4'b0100, 8'h00, DAT, 4'b0001, 32'h00000033, 4'b0100, 4'b0100);
    for (int c = 0; c < 5; c++)
      step("sticky_hold", 0, 4'b0110, 8'h00, DAT, 4'b0001, 32'h00000033, 4'b0100, 4'b0100);
    // Owner drops: in1 takes out0 in the same cycle.
    step("sticky_hand", 0, 4'b0010, 8'h00, DAT, 4'b0001, 32'h00000022, 4'b0010, 4'b0010);
    step("sticky_idle", 0, 4'b0000, 8'h00, DAT, 4'b0001, 32'h0, 4'b0000, 4'b0000);

    // Reset mid-packet: in3 owns out0 (ptr 1 -> scan 2,3), then rst drops it.
    step("rst_own3",   0, 4'b1000, 8'h00, DAT, 4'b0001, 32'h00000044, 4'b1000, 4'b1000);
    step("rst_own3b",  0, 4'b1010, 8'h00, DAT, 4'b0001, 32'h00000044, 4'b1000, 4'b1000);
    step("rst_assert", 1, 4'b1010, 8'h00, DAT, 4'b0001, 32'h0, 4'b0000, 4'b0000);
    step("rst_held",   1, 4'b1010, 8'h00, DAT, 4'b0001, 32'h0, 4'b0000, 4'b0000);
    // Released: arbitration restarts at input 0, so in1 beats in3.
    step("rst_rel1",   0, 4'b1010, 8'h00, DAT, 4'b0001, 32'h00000022, 4'b0010, 4'b0010);
    step("rst_keep1",  0, 4'b1010, 8'h00, DAT, 4'b0001, 32'h00000022, 4'b0010, 4'b0010);
    step("rst_then3",  0, 4'b1000, 8'h00, DAT, 4'b0001, 32'h00000044, 4'b1000, 4'b1000);

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crossbar_rr.md
Name: crossbar_rr

Overview:
- PORTS×PORTS combinational crossbar switch with one round-robin arbiter per output port. Used inside each NoC router node.
- Each input requests one output (dest/dest_en). The winning input's data word goes to that output with zero latency.
- The per-output backpressure/ack signal (bp_i) is routed back to the granted input.
- A grant is sticky: it is held for as long as its owner keeps requesting the same output (wormhole semantics).

Parameters:
- PORTS, 4, number of input ports and number of output ports (≥2).
- WIDTH, 8, bits per data word. Node usage: flit width + 1 enable bit.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- data_i[PORTS]  input  WIDTH each  data word presented by input i.
- bp_i[PORTS]  input  1 each  ack/backpressure from the consumer of output o.
- dest[PORTS]  input  e_dir (2 bits, values 0..PORTS-1) each  output requested by input i.
- dest_en[PORTS]  input  1 each  input i's request is valid.
- data_o[PORTS]  output  WIDTH each  data word driven on output o.
- bp_o[PORTS]  output  1 each  ack returned to input i.
- ack[PORTS]  output  1 each  input i currently holds a grant.

Behaviour:
- Request: input i requests output o when dest_en[i]=1 and dest[i]=o. Self-routing (o=i) is legal.
- Per-output state, one set for each output o:
  - owner[o]: index of the granting input.
  - valid[o]: owner is held.
  - ptr[o]: last granted index.
  - Reset values: valid=0, ptr=PORTS-1, so input 0 has first priority after reset.
- Combinational grant per output o:
  - If valid[o] and owner[o] still requests o, grant owner[o] (sticky, no preemption).
  - Otherwise grant the first requester scanning from ptr[o]+1 upward, modulo PORTS.
  - No requester means no grant.
- Grant timing: a grant is visible in the same cycle as the request, with zero latency. This lets a header flit be accepted in the cycle it appears.
- Registered update at posedge clk:
  - If output o has a grant g: owner[o]<=g, valid[o]<=1, ptr[o]<=g.
  - Else: valid[o]<=0, ptr[o] unchanged.
  - An owner that drops its request releases the output at the next edge. Another requester can win in the same cycle the owner drops.
- An input requests exactly one output, so it holds at most one grant.
- Outputs (all combinational):
  - data_o[o] = data_i[g] if output o has a grant g, else all zeros.
  - ack[i] = 1 iff input i is granted its requested output.
  - bp_o[i] = bp_i[dest[i]] if ack[i], else 0.
- Reset:
  - While rst=1, all state is held at reset values and all grants are forced off: data_o=0, ack=0, bp_o=0.
  - Asserting rst mid-packet drops every grant immediately.
  - After release, arbitration restarts from input 0.
- Contention:
  - Among new contenders, round-robin guarantees no input waits more than PORTS-1 grant turns.
  - Simultaneous requests to different outputs are independent, so up to PORTS transfers run in parallel.
- The registered grant state and the combinational outputs must always agree: one owner per output.

Decomposition:
- Package noc_types: e_dir enum (NORTH=0, EAST=1, SOUTH=2, WEST=3, 2-bit), plus flit types used elsewhere.
- Sub-module rr_arbiter (params N):
  - Inputs: req[N].
  - Outputs: one-hot gnt[N], gnt_valid.
  - Internal: ptr/owner registers and sticky rule.
  - Instantiated once per output.
- crossbar_rr builds the request matrix req[o][i] from dest/dest_en and implements the data/bp muxes.

Test Plan:
- Single request:
  - Stimulus: rst released, input 1 dest=2 dest_en=1 data_i[1]=0xA5, bp_i[2]=1.
  - Required: same cycle data_o[2]=0xA5, ack[1]=1, bp_o[1]=1. All other data_o=0.
- Contention and round-robin:
  - Stimulus: inputs 0 and 3 both request output 1 continuously for one cycle, then both drop and re-request.
  - Required: first grant to input 0 (ptr reset 3). After input 0 releases and both request again, the grant goes to input 3. Then back to 0.
- Stickiness:
  - Stimulus: input 2 owns output 0, then input 1 starts requesting 0 while input 2 keeps requesting for 5 cycles.
  - Required: ack[2] stays 1 and ack[1]=0 for all 5 cycles.
  - Then input 2 drops dest_en: ack[1]=1 in that same cycle.
- Parallel paths:
  - Stimulus: 0→1, 1→0, 2→3, 3→2 all enabled with distinct data.
  - Required: all four ack=1 and each data_o carries the matching input's data.
  - bp_i toggling is reflected on the corresponding bp_o.
- Disabled/no request:
  - Stimulus: dest=1 with dest_en=0.
  - Required: data_o[1]=0, ack=0, bp_o=0 regardless of bp_i.
- Reset mid-operation:
  - Stimulus: assert rst while input 3 owns output 0.
  - Required: immediately ack=0, data_o=0, bp_o=0.
  - After release with inputs 1 and 3 requesting output 0, input 1 is granted first.
